// File: rtl/systolic_writeback.sv
// Receives K-wide result rows into a small FIFO and writes them one word per cycle to
// OUTPUT_BASE + row_idx*K + col. Define WRITEBACK_RELU_EN to write negative elements as 0.
module systolic_writeback #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          ADDR_WIDTH       = 32,
  parameter int          ARRAY_SIZE_K_MAX = 8,
  parameter logic [31:0] OUTPUT_BASE      = 32'h00003000,
  parameter int          FIFO_DEPTH       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            M,
  input  logic [31:0]                            K,
  input  logic                                   row_valid,
  input  logic [31:0]                            row_idx,
  input  logic [DATA_WIDTH*ARRAY_SIZE_K_MAX-1:0] row_data,
  output logic                                   row_ready,
  output logic                                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [DATA_WIDTH-1:0]                  mem_data,
  output logic                                   done,
  output logic                                   overflow,
  output logic [1:0]                             dbg_state
);

  localparam int RW = DATA_WIDTH * ARRAY_SIZE_K_MAX;
  localparam int KW = $clog2(ARRAY_SIZE_K_MAX + 1);
  localparam int CW = (ARRAY_SIZE_K_MAX > 1) ? $clog2(ARRAY_SIZE_K_MAX) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [31:0]     m_reg;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   k_clamped;
  logic [31:0]     rows_done;
  logic [31:0]     rows_next;
  logic [CW-1:0]   col;
  logic [RW-1:0]   cur_data;
  logic [31:0]     cur_idx;

  logic [RW-1:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]     fifo_idx  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            last_col;

  logic [DATA_WIDTH-1:0] elems [ARRAY_SIZE_K_MAX];
  logic [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH-1:0] elem_out;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Handshake: a row transfers on any posedge where row_valid && row_ready; row_ready
  // depends only on the registered fill count, so it never combinationally follows row_valid.
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign row_ready = !full;
  assign push      = row_valid && row_ready;
  assign dbg_state = state;

  assign k_clamped = (K > 32'(ARRAY_SIZE_K_MAX)) ? KW'(ARRAY_SIZE_K_MAX) : KW'(K);
  assign rows_next = rows_done + 32'd1;
  assign last_col  = (KW'(col) == k_reg - KW'(1));

  // Reaching M rows has priority over popping, so surplus rows are never written.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE && rows_done != m_reg)
        pop = 1'b1;
      else if (state == WRITE && last_col && rows_next != m_reg)
        pop = 1'b1;
    end
  end

  for (genvar j = 0; j < ARRAY_SIZE_K_MAX; j++) begin : g_elem
    assign elems[j] = cur_data[j*DATA_WIDTH +: DATA_WIDTH];
  end

  assign elem      = elems[col];
  assign addr_next = ADDR_WIDTH'(OUTPUT_BASE) + ADDR_WIDTH'(cur_idx) * ADDR_WIDTH'(k_reg)
                   + ADDR_WIDTH'(col);

`ifdef WRITEBACK_RELU_EN
  assign elem_out = elem[DATA_WIDTH-1] ? '0 : elem;
`else
  assign elem_out = elem;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= row_data;
      fifo_idx[wr_ptr]  <= row_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (row_valid && !row_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_reg     <= M;
      k_reg     <= k_clamped;
      rows_done <= '0;
      col       <= '0;
      cur_data  <= '0;
      cur_idx   <= '0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      done      <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      case (state)
        IDLE: begin
          if (rows_done == m_reg) begin
            state <= DONE;
          end else if (!empty) begin
            // An empty row (K=0) is consumed here and still counts toward M.
            if (k_reg == '0) begin
              rows_done <= rows_next;
            end else begin
              cur_data <= fifo_data[rd_ptr];
              cur_idx  <= fifo_idx[rd_ptr];
              col      <= '0;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_wr_en <= 1'b1;
          mem_addr  <= addr_next;
          mem_data  <= elem_out;
          if (last_col) begin
            rows_done <= rows_next;
            if (rows_next == m_reg) begin
              state <= DONE;
            end else if (!empty) begin
              cur_data <= fifo_data[rd_ptr];
              cur_idx  <= fifo_idx[rd_ptr];
              col      <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for systolic_writeback: ordering, FIFO overflow, K clamp, mid-row reset,
// M=0 and the optional ReLU writeback.
module tb_systolic_writeback;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int KM = 8;
  localparam int RW = DW * KM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   m_in = '0;
  logic [31:0]   k_in = '0;
  logic          row_valid = 1'b0;
  logic [31:0]   row_idx = '0;
  logic [RW-1:0] row_data = '0;
  logic          row_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          done;
  logic          overflow;
  logic [1:0]    dbg_state;

  logic [63:0] exp_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int wr_count  = 0;
  int first_wr  = -1;
  int last_wr   = -1;

  always #5 clk = ~clk;

  systolic_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .M         (m_in),
    .K         (k_in),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .row_ready (row_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .done      (done),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_elem(input logic [31:0] d);
`ifdef WRITEBACK_RELU_EN
    return d[31] ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [RW-1:0] mk_row(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < KM; j++) r[j*DW +: DW] = 32'(base + j);
    return r;
  endfunction

  // Advance one clock and score any write the DUT made on that edge.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_wr_en) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("spurious_wr", {63'd0, mem_wr_en}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), {32'd0, e[63:32]});
        check("wr_data", 64'(mem_data), {32'd0, e[31:0]});
      end
    end
  endtask

  task automatic do_reset(input logic [31:0] m, input logic [31:0] k);
    rst       = 1'b1;
    m_in      = m;
    k_in      = k;
    row_valid = 1'b0;
    tick();
    check("rst_ready",    64'(row_ready), 64'd1);
    check("rst_wr_en",    64'(mem_wr_en), 64'd0);
    check("rst_addr",     64'(mem_addr),  64'd0);
    check("rst_data",     64'(mem_data),  64'd0);
    check("rst_done",     64'(done),      64'd0);
    check("rst_overflow", 64'(overflow),  64'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    wr_count = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  // Present one row honouring row_ready and queue the writes it should produce.
  task automatic push_row(input logic [31:0] idx, input logic [RW-1:0] data, input int k_eff);
    int b;
    logic [31:0] el;
    b = 0;
    while (!row_ready && b < 50) begin
      tick();
      b++;
    end
    check("ready_wait", 64'(row_ready), 64'd1);
    for (int j = 0; j < k_eff; j++) begin
      el = data[j*DW +: DW];
      exp_q.push_back({32'h0000_3000 + idx * 32'(k_eff) + 32'(j), exp_elem(el)});
    end
    row_valid = 1'b1;
    row_idx   = idx;
    row_data  = data;
    tick();
    row_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int push_cyc;
    int b;
    logic [RW-1:0] r;

    // M=2, K=3: two back-to-back rows, six consecutive writes.
    do_reset(32'd2, 32'd3);
    push_cyc = cyc + 1;
    push_row(32'd0, mk_row(1), 3);
    push_row(32'd1, mk_row(4), 3);
    wait_drain(30);
    check("t1_latency",   64'(first_wr), 64'(push_cyc + 2));
    check("t1_wr_count",  64'(wr_count), 64'd6);
    check("t1_no_bubble", 64'(last_wr - first_wr), 64'd5);
    check("t1_done_last", 64'(done), 64'd0);
    tick();
    check("t1_done",      64'(done), 64'd1);
    check("t1_wr_after",  64'(mem_wr_en), 64'd0);

    // M=0 keeps the FSM in DONE, so rows pile up: ready drops after 4, overflow on 5th.
    do_reset(32'd0, 32'd8);
    for (int i = 0; i < 6; i++) begin
      row_valid = 1'b1;
      row_idx   = 32'(i);
      row_data  = mk_row(i * 16);
      check("t2_ready",    64'(row_ready), (i < 4) ? 64'd1 : 64'd0);
      check("t2_overflow", 64'(overflow),  (i >= 5) ? 64'd1 : 64'd0);
      tick();
    end
    row_valid = 1'b0;
    tick();
    check("t2_overflow_end", 64'(overflow), 64'd1);
    check("t2_m0_done",      64'(done),     64'd1);
    repeat (4) tick();
    check("t2_no_writes",    64'(wr_count), 64'd0);

    // Same traffic honouring ready: 48 writes, no overflow, no bubble.
    do_reset(32'd6, 32'd8);
    for (int i = 0; i < 6; i++) push_row(32'(5 - i), mk_row(i * 16 + 1), 8);
    wait_drain(200);
    check("t2b_wr_count",  64'(wr_count), 64'd48);
    check("t2b_no_bubble", 64'(last_wr - first_wr), 64'd47);
    check("t2b_overflow",  64'(overflow), 64'd0);
    tick();
    check("t2b_done",      64'(done), 64'd1);

    // K=12 clamps to 8: row 5 lands at 0x3028..0x302F.
    do_reset(32'd1, 32'd12);
    push_row(32'd5, mk_row(32'h100), 8);
    wait_drain(50);
    tick();
    check("t3_done",     64'(done), 64'd1);
    repeat (3) tick();
    check("t3_wr_count", 64'(wr_count), 64'd8);

    // Reset after 3 of 8 writes aborts; a fresh run completes.
    do_reset(32'd1, 32'd8);
    push_row(32'd2, mk_row(32'h40), 8);
    b = 0;
    while (wr_count < 3 && b < 40) begin
      tick();
      b++;
    end
    check("t4_three_writes", 64'(wr_count), 64'd3);
    do_reset(32'd1, 32'd8);
    repeat (3) tick();
    check("t4_no_writes", 64'(wr_count), 64'd0);
    check("t4_not_done",  64'(done), 64'd0);
    push_row(32'd2, mk_row(32'h40), 8);
    wait_drain(50);
    check("t4_wr_count",  64'(wr_count), 64'd8);
    tick();
    check("t4_done",      64'(done), 64'd1);

    // M=0 straight out of reset.
    do_reset(32'd0, 32'd3);
    tick();
    tick();
    check("t5_done",     64'(done), 64'd1);
    repeat (5) tick();
    check("t5_no_write", 64'(wr_count), 64'd0);

    // Sign-bit elements: zeroed when ReLU is built in, raw otherwise.
    do_reset(32'd1, 32'd3);
    r = '0;
    r[0*DW +: DW] = 32'hFFFF_FFFF;
    r[1*DW +: DW] = 32'd7;
    r[2*DW +: DW] = 32'h8000_0000;
    push_row(32'd0, r, 3);
    wait_drain(30);
    check("t6_wr_count", 64'(wr_count), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_writeback.md
Name: systolic_writeback

Overview:
- Receiving end of the systolic array's result-row interface.
- Accepts one K-wide result row per handshake and buffers rows in a small FIFO.
- Serializes each row into single-word writes to the shared data memory at OUTPUT_BASE + row_idx*K + j.
- Replaces the per-column parallel memory writes in the top level with one write port.

Parameters:
- DATA_WIDTH, 32, width of one result element.
- ADDR_WIDTH, 32, memory word-address width.
- ARRAY_SIZE_K_MAX, 8, max elements per row; row bus is DATA_WIDTH*ARRAY_SIZE_K_MAX bits.
- OUTPUT_BASE, 32'h00003000, word address of output matrix element (0,0).
- FIFO_DEPTH, 4, row FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- M  input  32  number of rows expected; sampled while rst=1, ignored otherwise.
- K  input  32  elements per row; sampled while rst=1; values > ARRAY_SIZE_K_MAX clamp to ARRAY_SIZE_K_MAX.
- row_valid  input  1  a row is presented.
- row_idx  input  32  output row index of the presented row.
- row_data  input  DATA_WIDTH*ARRAY_SIZE_K_MAX  element j at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH].
- row_ready  output  1  FIFO can accept a row this cycle.
- mem_wr_en  output  1  write strobe, one word per cycle.
- mem_addr  output  ADDR_WIDTH  write word address.
- mem_data  output  DATA_WIDTH  write data.
- done  output  1  all M rows written; sticky until rst.
- overflow  output  1  sticky; row_valid seen while row_ready=0.

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, counters cleared, state IDLE, M and K latched.
  - Outputs during and after reset: row_ready=1, mem_wr_en=0, mem_addr=0, mem_data=0, done=0, overflow=0.
  - rst asserted mid-operation aborts immediately: no further writes, FIFO contents discarded.
- Handshake: row_ready = !fifo_full (combinational from registered count). Push occurs when row_valid && row_ready.
  - row_valid && !row_ready: row dropped and overflow set (sticky).
- Pop is independent of push. Push and pop in the same cycle when full:
  - Push refused, because row_ready already reflects full.
  - The pop still occurs.
  - Next cycle row_ready=1.
- FIFO pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- State machine:
  - IDLE: if FIFO non-empty, pop head into row register, col=0, go WRITE. If rows_done==M, go DONE.
  - WRITE: each cycle, mem_wr_en=1, mem_addr=OUTPUT_BASE+row_idx*K+col (ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH), mem_data=element col; col++.
    - On col==K-1, rows_done++.
    - On col==K-1 with FIFO non-empty: pop next row in same cycle, col=0, stay WRITE (no bubble).
    - On col==K-1 with FIFO empty: go IDLE; go DONE directly if rows_done+1==M.
  - DONE: done=1, mem_wr_en=0. Further pushes are accepted into the FIFO but never written. Exit only via rst.
- Outputs mem_wr_en, mem_addr and mem_data are registered.
- Latency: row pushed at edge t into an empty FIFO with state IDLE → pop at t+1 → first write visible after edge t+2. Throughput: one word per cycle.
- K=0: each popped row costs one IDLE cycle, produces no writes, and counts toward M.
- M=0: DONE reached on first cycle after rst deasserts.
- row_idx is not checked against M; duplicate indices overwrite.

Optional Feature:
- Macro WRITEBACK_RELU_EN.
- Defined: mem_data = element if element bit[DATA_WIDTH-1]==0, else 0. This is a signed ReLU fused into writeback; addresses and timing are unchanged.
- Undefined: mem_data is the raw element.

Test Plan:
- M=2,K=3: push row0 {1,2,3} then row1 {4,5,6}, back-to-back → six consecutive writes 0x3000..0x3005 = 1..6, no bubble; done=1 the cycle after the last write.
- FIFO_DEPTH=4, K=8, row_valid held high with 6 rows → row_ready drops after 4 accepted. With valid held, overflow=1. A variant that honours ready sees overflow stay 0, all 48 writes correct.
- K=12 (clamped to 8), M=1, row_idx=5 → writes at 0x3028..0x302F, exactly 8 writes.
- rst pulsed after 3 of 8 writes of a row → mem_wr_en=0 next cycle, row_ready=1, done=0. Re-run with M=1 completes normally.
- M=0 → done=1 one cycle after rst falls; no writes ever.
- WRITEBACK_RELU_EN defined, row {0xFFFFFFFF, 7, 0x80000000} → data 0, 7, 0. Undefined → raw values.
